// File: rtl/cook_timer_ctrl.sv
// Microwave cook-cycle sequencer: BCD M:SS keypad entry, 1 Hz countdown from an
// internal prescaler, door-open pause, stop/cancel and a one-cycle expiry pulse.
module cook_timer_ctrl #(
    parameter int unsigned TICK_DIV = 100
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] key_digit,
    input  logic       key_valid,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    output logic       mag_on,
    output logic [3:0] min_bcd,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] state,
    output logic       done
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StEntry = 3'd1,
        StCook  = 3'd2,
        StPause = 3'd3,
        StDone  = 3'd4
    } state_e;

    localparam logic [15:0] TickLast = 16'(TICK_DIV - 1);

    state_e      r_state, w_state_d;
    logic [3:0]  r_min, r_tens, r_ones;
    logic [3:0]  w_min_d, w_tens_d, w_ones_d;
    logic [15:0] r_presc, w_presc_d;
    logic        r_done, w_done_d;

    logic w_key_ok;
    logic w_time_zero;
    logic w_last_sec;
    logic w_tick;

    assign w_key_ok    = key_valid && (key_digit <= 4'd9);
    assign w_time_zero = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);
    assign w_last_sec  = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd1);
    assign w_tick      = (r_presc == TickLast);

    always_comb begin
        w_state_d = r_state;
        w_min_d   = r_min;
        w_tens_d  = r_tens;
        w_ones_d  = r_ones;
        w_presc_d = 16'd0;
        w_done_d  = 1'b0;

        case (r_state)
            StIdle: begin
                if (!stop && w_key_ok) begin
                    w_min_d   = r_tens;
                    w_tens_d  = r_ones;
                    w_ones_d  = key_digit;
                    w_state_d = StEntry;
                end
            end
            StEntry: begin
                if (stop) begin
                    w_state_d = StIdle;
                    w_min_d   = 4'd0;
                    w_tens_d  = 4'd0;
                    w_ones_d  = 4'd0;
                end else if (start) begin
                    // A refused start still outranks a same-cycle key.
                    if (door_closed && !w_time_zero) begin
                        w_state_d = StCook;
                    end
                end else if (w_key_ok) begin
                    w_min_d  = r_tens;
                    w_tens_d = r_ones;
                    w_ones_d = key_digit;
                end
            end
            StCook: begin
                if (stop || !door_closed) begin
                    w_state_d = StPause;
                end else if (w_tick) begin
                    if (r_ones != 4'd0) begin
                        w_ones_d = r_ones - 4'd1;
                    end else if (r_tens != 4'd0) begin
                        w_tens_d = r_tens - 4'd1;
                        w_ones_d = 4'd9;
                    end else begin
                        w_min_d  = r_min - 4'd1;
                        w_tens_d = 4'd5;
                        w_ones_d = 4'd9;
                    end
                    if (w_last_sec) begin
                        w_state_d = StDone;
                        w_done_d  = 1'b1;
                    end
                end else begin
                    w_presc_d = r_presc + 16'd1;
                end
            end
            StPause: begin
                if (stop) begin
                    w_state_d = StIdle;
                    w_min_d   = 4'd0;
                    w_tens_d  = 4'd0;
                    w_ones_d  = 4'd0;
                end else if (start && door_closed) begin
                    w_state_d = StCook;
                end
            end
            StDone: begin
                if (stop || !door_closed) begin
                    w_state_d = StIdle;
                    w_min_d   = 4'd0;
                    w_tens_d  = 4'd0;
                    w_ones_d  = 4'd0;
                end
            end
            default: begin
                w_state_d = StIdle;
                w_min_d   = 4'd0;
                w_tens_d  = 4'd0;
                w_ones_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= StIdle;
            r_min   <= 4'd0;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
            r_presc <= 16'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_min   <= w_min_d;
            r_tens  <= w_tens_d;
            r_ones  <= w_ones_d;
            r_presc <= w_presc_d;
            r_done  <= w_done_d;
        end
    end

    assign mag_on   = (r_state == StCook);
    assign min_bcd  = r_min;
    assign sec_tens = r_tens;
    assign sec_ones = r_ones;
    assign state    = r_state;
    assign done     = r_done;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Bench for cook_timer_ctrl: time kept as a decimal number MSS in the model,
// checked every cycle, plus directed literal checks along the test sequence.
module tb_cook_timer_ctrl;

    localparam int unsigned TD = 4;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic [3:0] key_digit = 4'd0;
    logic       key_valid = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       door_closed = 1'b1;
    logic       mag_on;
    logic [3:0] min_bcd, sec_tens, sec_ones;
    logic [2:0] state;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    cook_timer_ctrl #(.TICK_DIV(TD)) dut (
        .clock      (clock),
        .clear      (clear),
        .key_digit  (key_digit),
        .key_valid  (key_valid),
        .start      (start),
        .stop       (stop),
        .door_closed(door_closed),
        .mag_on     (mag_on),
        .min_bcd    (min_bcd),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .state      (state),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Model: mode 0..4 as in the state output, time as the decimal number M*100+T*10+O.
    int m_mode = 0;
    int m_n = 0;
    int m_cnt = 0;
    int m_done = 0;
    bit m_valid = 1'b0;

    always @(posedge clock) begin
        m_done = 0;
        if (clear) begin
            m_mode = 0; m_n = 0; m_cnt = 0;
            m_valid = 1'b1;
        end else begin
            case (m_mode)
                0: if (!stop && key_valid && key_digit <= 9) begin
                    m_n = (m_n * 10 + int'(key_digit)) % 1000;
                    m_mode = 1;
                end
                1: if (stop) begin
                    m_mode = 0; m_n = 0;
                end else if (start) begin
                    if (door_closed && m_n != 0) begin m_mode = 2; m_cnt = 0; end
                end else if (key_valid && key_digit <= 9) begin
                    m_n = (m_n * 10 + int'(key_digit)) % 1000;
                end
                2: if (stop || !door_closed) begin
                    m_mode = 3; m_cnt = 0;
                end else if (m_cnt == TD - 1) begin
                    m_cnt = 0;
                    m_n = (m_n % 100 == 0) ? m_n - 41 : m_n - 1;
                    if (m_n == 0) begin m_mode = 4; m_done = 1; end
                end else begin
                    m_cnt = m_cnt + 1;
                end
                3: if (stop) begin
                    m_mode = 0; m_n = 0;
                end else if (start && door_closed) begin
                    m_mode = 2; m_cnt = 0;
                end
                default: if (stop || !door_closed) begin m_mode = 0; m_n = 0; end
            endcase
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            vectors++;
            if (int'(state) != m_mode || int'(min_bcd) != m_n / 100
                || int'(sec_tens) != (m_n / 10) % 10 || int'(sec_ones) != m_n % 10
                || mag_on != (m_mode == 2) || int'(done) != m_done) begin
                miscompares++;
                $display("FAIL model t=%0t: got st=%0d %0d:%0d%0d mag=%0d done=%0d, want st=%0d %0d:%0d%0d mag=%0d done=%0d",
                         $time, state, min_bcd, sec_tens, sec_ones, mag_on, done,
                         m_mode, m_n / 100, (m_n / 10) % 10, m_n % 10, (m_mode == 2), m_done);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic press(input int d);
        key_digit = 4'(d);
        key_valid = 1'b1;
        step(1);
        key_valid = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_time(input string name, input int exp_mss);
        chk(name, int'(min_bcd) * 100 + int'(sec_tens) * 10 + int'(sec_ones), exp_mss);
    endtask

    initial begin
        // Reset with garbage on the inputs.
        for (int i = 0; i < 2; i++) begin
            key_digit = 4'($urandom); key_valid = 1'($urandom); start = 1'($urandom);
            stop = 1'($urandom); door_closed = 1'($urandom);
            step(1);
        end
        chk("reset_state", int'(state), 0);
        chk_time("reset_time", 0);
        chk("reset_mag", int'(mag_on), 0);
        chk("reset_done", int'(done), 0);
        clear = 1'b0; key_valid = 1'b0; stop = 1'b0; door_closed = 1'b1;
        start = 1'b1;
        step(3);
        chk("idle_start_ignored", int'(state), 0);
        start = 1'b0;

        press(1); press(3); press(0); press(12);
        chk_time("entry_130", 130);
        chk("entry_state", int'(state), 1);
        door_closed = 1'b0; start = 1'b1;
        step(2);
        chk("start_door_open_state", int'(state), 1);
        chk("start_door_open_mag", int'(mag_on), 0);
        door_closed = 1'b1; stop = 1'b1;
        step(1);
        chk("start_stop_entry_state", int'(state), 0);
        chk_time("start_stop_entry_time", 0);
        start = 1'b0; stop = 1'b0;

        // 1:00 countdown with borrow from minutes.
        press(1); press(0); press(0);
        start = 1'b1; step(1); start = 1'b0;
        chk("cook_mag", int'(mag_on), 1);
        step(TD - 1);
        chk_time("before_first_tick", 100);
        step(1);
        chk_time("first_tick_059", 59);
        step(9 * TD);
        chk_time("tick_050", 50);
        step(TD);
        chk_time("tick_049", 49);
        step(4 * TD);
        chk_time("tick_045", 45);
        clear = 1'b1; step(1); clear = 1'b0;
        chk("clear_cook_state", int'(state), 0);
        chk_time("clear_cook_time", 0);
        chk("clear_cook_mag", int'(mag_on), 0);
        chk("clear_cook_done", int'(done), 0);

        // Door pause, resume and expiry.
        press(0); press(0); press(3);
        start = 1'b1; step(1); start = 1'b0;
        step(TD);
        chk_time("pause_pre_002", 2);
        step(1);
        door_closed = 1'b0; step(1);
        chk("pause_state", int'(state), 3);
        chk("pause_mag", int'(mag_on), 0);
        step(20);
        chk_time("pause_frozen", 2);
        door_closed = 1'b1; start = 1'b1; step(1); start = 1'b0;
        chk("resume_state", int'(state), 2);
        step(2 * TD - 1);
        chk_time("resume_001", 1);
        step(1);
        chk("expire_state", int'(state), 4);
        chk("expire_done", int'(done), 1);
        chk_time("expire_time", 0);
        step(1);
        chk("done_pulse_once", int'(done), 0);
        chk("done_hold_state", int'(state), 4);
        door_closed = 1'b0; step(1); door_closed = 1'b1;
        chk("done_door_idle", int'(state), 0);

        // Stop in COOK pauses, stop again cancels.
        press(2); press(0);
        start = 1'b1; step(1); start = 1'b0;
        step(2);
        stop = 1'b1; step(1); stop = 1'b0;
        chk("cook_stop_state", int'(state), 3);
        chk_time("cook_stop_time", 20);
        step(1);
        stop = 1'b1; step(1); stop = 1'b0;
        chk("pause_stop_state", int'(state), 0);
        chk_time("pause_stop_time", 0);

        // Unnormalised tens digit and keys ignored while cooking.
        press(1); press(7); press(0);
        start = 1'b1; step(1); start = 1'b0;
        press(5);
        step(TD - 1);
        chk_time("unnorm_169", 169);
        stop = 1'b1; step(2); stop = 1'b0;
        chk("final_idle", int'(state), 0);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
